// File: rtl/prm_chk_pkg.sv
// rtl/prm_chk_pkg.sv - shared types for the PRM edge check scheduler
package prm_chk_pkg;

   localparam int CODE_W = 15;

   typedef logic [CODE_W-1:0] edge_code_t;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      CHECK,
      EMIT,
      DONE
   } state_e;

endpackage

// File: rtl/prm_chk_reduce.sv
// rtl/prm_chk_reduce.sv - masked OR-reduce of the checker bank into the blocked flag
module prm_chk_reduce #(
   parameter int N_CHK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en_i,
   input  logic [N_CHK-1:0] chk_mask_i,
   input  logic [N_CHK-1:0] occ_i,
   output logic             blk_o
);

   logic blk_q;
   logic blk_d;

   // Only occupied cells can block an edge.
   assign blk_d = |(chk_mask_i & occ_i);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blk_q <= 1'b0;
      end else if (en_i) begin
         blk_q <= blk_d;
      end
   end

   assign blk_o = blk_q;

endmodule

// File: rtl/prm_edge_chk_sched.sv
// rtl/prm_edge_chk_sched.sv - sequences PRM edges through the obstacle checker bank
// Optional early exit on first blocked edge: PRM_EARLY_EXIT_EN.
module prm_edge_chk_sched
   import prm_chk_pkg::*;
#(
   parameter int N_CHK = 8,
   parameter int AW    = 10,
   parameter int CNT_W = AW + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [AW-1:0]     start_idx,
   input  logic [CNT_W-1:0]  edge_cnt,
   input  logic [N_CHK-1:0]  occ_en,
   output logic              busy,
   output logic              done,
   output logic              done_early,
   output logic              rom_en,
   output logic [AW-1:0]     rom_addr,
   input  edge_code_t        rom_data,
   output edge_code_t        chk_code,
   input  logic [N_CHK-1:0]  chk_mask,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [AW-1:0]     res_idx,
   output logic              res_blocked,
   output logic [CNT_W-1:0]  blk_cnt
);

   state_e           state_q;
   logic [AW-1:0]    idx_q;
   logic [AW-1:0]    idx_d;
   logic [CNT_W-1:0] rem_q;
   logic [CNT_W-1:0] rem_d;
   logic [CNT_W-1:0] blk_cnt_q;
   logic [CNT_W-1:0] blk_cnt_d;
   logic [N_CHK-1:0] occ_q;
   edge_code_t       chk_code_q;
   logic             busy_q;
   logic             done_q;
   logic             rom_en_q;
   logic             res_valid_q;
   logic             blk_q;
   logic             stop_d;
`ifdef PRM_EARLY_EXIT_EN
   logic             done_early_q;
   logic             early_d;
`endif

   prm_chk_reduce #(
      .N_CHK(N_CHK)
   ) u_reduce (
      .clk        (clk),
      .rst        (rst),
      .en_i       (state_q == CHECK),
      .chk_mask_i (chk_mask),
      .occ_i      (occ_q),
      .blk_o      (blk_q)
   );

   assign idx_d     = idx_q + AW'(1);
   assign rem_d     = rem_q - CNT_W'(1);
   assign blk_cnt_d = blk_cnt_q + CNT_W'(blk_q);

`ifdef PRM_EARLY_EXIT_EN
   assign early_d = blk_q & (rem_d != '0);
   assign stop_d  = (rem_d == '0) | blk_q;
`else
   assign stop_d  = (rem_d == '0);
`endif

   // Pulse outputs (rom_en, done) are raised on entry to the state that owns them.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         rem_q       <= '0;
         blk_cnt_q   <= '0;
         occ_q       <= '0;
         chk_code_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         rom_en_q    <= 1'b0;
         res_valid_q <= 1'b0;
`ifdef PRM_EARLY_EXIT_EN
         done_early_q <= 1'b0;
`endif
      end else begin
         rom_en_q <= 1'b0;
         done_q   <= 1'b0;
`ifdef PRM_EARLY_EXIT_EN
         done_early_q <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (start) begin
                  busy_q    <= 1'b1;
                  blk_cnt_q <= '0;
                  if (edge_cnt != '0) begin
                     idx_q    <= start_idx;
                     rem_q    <= edge_cnt;
                     occ_q    <= occ_en;
                     rom_en_q <= 1'b1;
                     state_q  <= FETCH;
                  end else begin
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end
               end
            end
            FETCH: begin
               state_q <= LOAD;
            end
            LOAD: begin
               chk_code_q <= rom_data;
               state_q    <= CHECK;
            end
            CHECK: begin
               res_valid_q <= 1'b1;
               state_q     <= EMIT;
            end
            EMIT: begin
               if (res_ready) begin
                  res_valid_q <= 1'b0;
                  blk_cnt_q   <= blk_cnt_d;
                  idx_q       <= idx_d;
                  rem_q       <= rem_d;
                  if (stop_d) begin
                     done_q  <= 1'b1;
`ifdef PRM_EARLY_EXIT_EN
                     done_early_q <= early_d;
`endif
                     state_q <= DONE;
                  end else begin
                     rom_en_q <= 1'b1;
                     state_q  <= FETCH;
                  end
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign rom_en      = rom_en_q;
   assign rom_addr    = idx_q;
   assign chk_code    = chk_code_q;
   assign res_valid   = res_valid_q;
   assign res_idx     = idx_q;
   assign res_blocked = blk_q;
   assign blk_cnt     = blk_cnt_q;
`ifdef PRM_EARLY_EXIT_EN
   assign done_early  = done_early_q;
`else
   assign done_early  = 1'b0;
`endif

endmodule

// File: tb/tb_prm_edge_chk_sched.sv
// tb/tb_prm_edge_chk_sched.sv - scoreboard bench for prm_edge_chk_sched
module tb_prm_edge_chk_sched;

   localparam int AW    = 10;
   localparam int CNT_W = 11;
   localparam int N_CHK = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [AW-1:0]    start_idx = '0;
   logic [CNT_W-1:0] edge_cnt = '0;
   logic [N_CHK-1:0] occ_en = '0;
   logic             busy, done, done_early, rom_en;
   logic [AW-1:0]    rom_addr;
   logic [14:0]      rom_data = '0;
   logic [14:0]      chk_code;
   logic [N_CHK-1:0] chk_mask;
   logic             res_valid;
   logic             res_ready = 1'b1;
   logic [AW-1:0]    res_idx;
   logic             res_blocked;
   logic [CNT_W-1:0] blk_cnt;

   always #5 clk = ~clk;

   prm_edge_chk_sched #(.N_CHK(N_CHK), .AW(AW), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .start(start), .start_idx(start_idx), .edge_cnt(edge_cnt),
      .occ_en(occ_en), .busy(busy), .done(done), .done_early(done_early), .rom_en(rom_en),
      .rom_addr(rom_addr), .rom_data(rom_data), .chk_code(chk_code), .chk_mask(chk_mask),
      .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx),
      .res_blocked(res_blocked), .blk_cnt(blk_cnt)
   );

   // Edge ROM and a checker bank whose edge_mask is the low byte of the code.
   logic [14:0] rom_mem [1024];
   always @(posedge clk) if (rom_en) rom_data <= rom_mem[rom_addr];
   assign chk_mask = chk_code[7:0];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_pass = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   typedef struct {
      logic [AW-1:0] idx;
      logic          blk;
   } exp_t;
   exp_t sb[$];

   task automatic push(input logic [AW-1:0] i, input logic b);
      exp_t e;
      e.idx = i;
      e.blk = b;
      sb.push_back(e);
   endtask

   int n_rom = 0, n_valid = 0, n_done = 0, n_early = 0;
   always @(negedge clk) begin
      if (!rst) begin
         if (rom_en)     n_rom   <= n_rom + 1;
         if (res_valid)  n_valid <= n_valid + 1;
         if (done)       n_done  <= n_done + 1;
         if (done_early) n_early <= n_early + 1;
      end
   end

   exp_t mon_e;
   always @(negedge clk) begin
      if (!rst && res_valid && res_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_result", 1, 0);
         end else begin
            mon_e = sb.pop_front();
            check("res_idx", res_idx, mon_e.idx);
            check("res_blocked", res_blocked, mon_e.blk);
         end
      end
   end

   task automatic start_job(input logic [AW-1:0] sidx, input logic [CNT_W-1:0] cnt,
                            input logic [N_CHK-1:0] occ, output int s);
      @(negedge clk);
      start_idx = sidx;
      edge_cnt  = cnt;
      occ_en    = occ;
      start     = 1'b1;
      s         = cyc;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input int s, input int budget, output int lat, output logic early);
      lat   = -1;
      early = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         if (done) begin
            lat   = cyc - s;
            early = done_early;
            check("busy_with_done", busy, 1);
            break;
         end
      end
      if (lat < 0) check("done_timeout", 0, 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int s, lat, fv, d0, r0, v0;
      int bv, bi, bb, br;
      logic early;
      for (int i = 0; i < 1024; i++) rom_mem[i] = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rom_en", rom_en, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_blk_cnt", blk_cnt, 0);
      check("rst_chk_code", chk_code, 0);
      check("rst_rom_addr", rom_addr, 0);
      rst = 1'b0;

      // 1: three free edges from index 5
      push(5, 0); push(6, 0); push(7, 0);
      start_job(5, 3, 8'hFF, s);
      fv = -1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (res_valid) begin fv = cyc - s; break; end
      end
      check("t1_first_valid", fv, 4);
      wait_done(s, 40, lat, early);
      check("t1_done_cycle", lat, 13);
      check("t1_blk_cnt", blk_cnt, 0);
      @(negedge clk);
      check("t1_busy_after", busy, 0);

      // 2: occupancy is latched; the later occ_en change must not block edge 21
      rom_mem[20] = 15'h0004;
      rom_mem[21] = 15'h00FB;
      push(20, 1); push(21, 0);
      start_job(20, 2, 8'h04, s);
      occ_en = 8'hFF;
      wait_done(s, 40, lat, early);
      check("t2_done_cycle", lat, 9);
      check("t2_blk_cnt", blk_cnt, 1);

      // 3: backpressure for 10 cycles in EMIT
      rom_mem[40] = 15'h0010;
      rom_mem[41] = 15'h7F00;
      push(40, 1); push(41, 0);
      res_ready = 1'b0;
      start_job(40, 2, 8'h10, s);
      fv = -1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (res_valid) begin fv = cyc - s; break; end
      end
      check("t3_first_valid", fv, 4);
      bv = 0; bi = 0; bb = 0; br = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (res_valid !== 1'b1) bv++;
         if (res_idx !== 10'd40) bi++;
         if (res_blocked !== 1'b1) bb++;
         if (rom_en !== 1'b0) br++;
      end
      check("t3_valid_held", bv, 0);
      check("t3_idx_held", bi, 0);
      check("t3_blocked_held", bb, 0);
      check("t3_no_rom_stall", br, 0);
      @(posedge clk);
      #1 res_ready = 1'b1;
      wait_done(s, 40, lat, early);
      check("t3_blk_cnt", blk_cnt, 1);

      // 4: index wraps from 1023 to 0
      push(1023, 0); push(0, 0);
      start_job(1023, 2, 8'hFF, s);
      wait_done(s, 40, lat, early);
      check("t4_done_cycle", lat, 9);
      check("t4_blk_cnt", blk_cnt, 0);

      // 5: empty job, then start while busy is ignored
      r0 = n_rom; v0 = n_valid;
      start_job(0, 0, 8'hFF, s);
      wait_done(s, 5, lat, early);
      check("t5_empty_done_within_2", (lat >= 1 && lat <= 2), 1);
      repeat (2) @(negedge clk);
      check("t5_no_rom_en", n_rom - r0, 0);
      check("t5_no_res_valid", n_valid - v0, 0);
      check("t5_busy_after", busy, 0);
      d0 = n_done;
      push(60, 0);
      start_job(60, 1, 8'hFF, s);
      @(negedge clk);
      start_idx = 100; edge_cnt = 0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(s, 20, lat, early);
      check("t5_job_done_cycle", lat, 5);
      repeat (4) @(negedge clk);
      check("t5_single_done", n_done - d0, 1);

      // 6: reset during CHECK aborts the job silently
      rom_mem[70] = 15'h1234;
      d0 = n_done;
      start_job(70, 3, 8'hFF, s);
      for (int k = 0; k < 10 && cyc != s + 3; k++) @(negedge clk);
      check("t6_reached_check", cyc - s, 3);
      rst = 1'b1;
      #1;
      check("t6_busy", busy, 0);
      check("t6_rom_en", rom_en, 0);
      check("t6_res_valid", res_valid, 0);
      check("t6_chk_code", chk_code, 0);
      check("t6_res_idx", res_idx, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (20) @(negedge clk);
      check("t6_no_done", n_done - d0, 0);

      // 7: second of five edges blocked
      rom_mem[81] = 15'h0001;
      d0 = n_early;
`ifdef PRM_EARLY_EXIT_EN
      push(80, 0); push(81, 1);
      start_job(80, 5, 8'h01, s);
      wait_done(s, 60, lat, early);
      check("t7_done_cycle", lat, 9);
      check("t7_done_early", early, 1);
      check("t7_blk_cnt", blk_cnt, 1);
      repeat (2) @(negedge clk);
      check("t7_early_count", n_early - d0, 1);
`else
      push(80, 0); push(81, 1); push(82, 0); push(83, 0); push(84, 0);
      start_job(80, 5, 8'h01, s);
      wait_done(s, 60, lat, early);
      check("t7_done_cycle", lat, 21);
      check("t7_done_early", early, 0);
      check("t7_blk_cnt", blk_cnt, 1);
      repeat (2) @(negedge clk);
      check("t7_early_count", n_early - d0, 0);
`endif

      repeat (3) @(negedge clk);
      check("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
